// File: rtl/clock_hex_display.sv
// Avalon-MM peripheral driving four active-low 7-segment digits with per-digit blink and a tick timer.
// Optional: define CLOCK_HEX_LEADING_ZERO_BLANK_EN to add CONTROL bit9 (blank a leading zero on digit 3).

module clock_hex_digit (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] code,
   input  logic       enable,
   input  logic       blink,
   input  logic       phase,
   input  logic       force_blank,
   output logic [6:0] seg
);
   logic [6:0] dec;
   logic       blank;

   always_comb begin
      dec = 7'h7F;
      case (code)
         4'h0: dec = 7'h40;
         4'h1: dec = 7'h79;
         4'h2: dec = 7'h24;
         4'h3: dec = 7'h30;
         4'h4: dec = 7'h19;
         4'h5: dec = 7'h12;
         4'h6: dec = 7'h02;
         4'h7: dec = 7'h78;
         4'h8: dec = 7'h00;
         4'h9: dec = 7'h10;
         4'hA: dec = 7'h08;
         4'hB: dec = 7'h03;
         4'hC: dec = 7'h46;
         4'hD: dec = 7'h21;
         4'hE: dec = 7'h06;
         default: dec = 7'h7F;
      endcase
   end

   // Code F doubles as "no digit" so software can blank a position without touching CONTROL.
   assign blank = ~enable | (code == 4'hF) | (blink & phase) | force_blank;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) seg <= 7'h7F;
      else          seg <= blank ? 7'h7F : dec;
   end
endmodule

module clock_hex_display #(
   parameter logic [31:0] BLINK_DIV_DEFAULT = 32'd25000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3
);
   localparam int NUM_DIGITS = 4;

   typedef struct packed {
      logic       irq_en;
      logic [3:0] blink_mask;
      logic       enable;
   } ctrl_t;

   logic                             wr;
   logic [NUM_DIGITS-1:0][3:0]       digits;
   ctrl_t                            ctrl;
   logic                             lzb;
   logic [31:0]                      divisor;
   logic [31:0]                      count;
   logic [31:0]                      reload;
   logic                             phase;
   logic                             tick;
   logic                             rollover;
   logic [31:0]                      rd_mux;
   logic [NUM_DIGITS-1:0]            force_blank;
   logic [NUM_DIGITS-1:0][6:0]       segs;

   assign wr = chipselect & ~write_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digits  <= 16'hFFFF;
         ctrl    <= '0;
         divisor <= BLINK_DIV_DEFAULT;
      end else if (wr) begin
         case (address)
            2'd0: digits  <= writedata[15:0];
            2'd1: ctrl    <= '{irq_en: writedata[8], blink_mask: writedata[7:4], enable: writedata[0]};
            2'd2: divisor <= writedata;
            default: ;
         endcase
      end
   end

`ifdef CLOCK_HEX_LEADING_ZERO_BLANK_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   lzb <= 1'b0;
      else if (wr && address == 2'd1) lzb <= writedata[9];
   end
`else
   assign lzb = 1'b0;
`endif

   // A divisor of 0 is treated as 1, so the reload value saturates at 0.
   assign reload   = (divisor == 32'd0) ? 32'd0 : divisor - 32'd1;
   assign rollover = (count == 32'd0) && !(wr && address == 2'd2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= BLINK_DIV_DEFAULT - 32'd1;
         phase <= 1'b0;
      end else if (wr && address == 2'd2) begin
         count <= (writedata == 32'd0) ? 32'd0 : writedata - 32'd1;
      end else if (count == 32'd0) begin
         count <= reload;
         phase <= ~phase;
      end else begin
         count <= count - 32'd1;
      end
   end

   // Set has priority over the clear so a tick landing on a STATUS write is not lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        tick <= 1'b0;
      else if (rollover)                   tick <= 1'b1;
      else if (wr && address == 2'd3)      tick <= 1'b0;
   end

   assign irq = tick & ctrl.irq_en;

   always_comb begin
      rd_mux = 32'd0;
      case (address)
         2'd0: rd_mux = {16'd0, digits};
         2'd1: rd_mux = {22'd0, lzb, ctrl.irq_en, ctrl.blink_mask, 3'd0, ctrl.enable};
         2'd2: rd_mux = divisor;
         default: rd_mux = {30'd0, phase, tick};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= 32'd0;
      else          readdata <= rd_mux;
   end

   assign force_blank = {lzb & (digits[3] == 4'h0), 3'b000};

   for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_digit
      clock_hex_digit u_digit (
         .clk         (clk),
         .reset_n     (reset_n),
         .code        (digits[n]),
         .enable      (ctrl.enable),
         .blink       (ctrl.blink_mask[n]),
         .phase       (phase),
         .force_blank (force_blank[n]),
         .seg         (segs[n])
      );
   end

   assign hex0 = segs[0];
   assign hex1 = segs[1];
   assign hex2 = segs[2];
   assign hex3 = segs[3];
endmodule
